// File: rtl/seccion_scheduler.sv
// rtl/seccion_scheduler.sv - frame-synchronous display section sequencer
// Holds each section for DWELL_FRAMES frames; host pause/jump changes land on frame boundaries.
module seccion_scheduler #(
  parameter int NUM_SECTIONS = 5,
  parameter int DWELL_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        enable,
  input  logic        pause,
  input  logic        jump_req,
  input  logic [2:0]  jump_sel,
  output logic        jump_ack,
  output logic [2:0]  seccion,
  output logic        seccion_change,
  output logic [15:0] dwell_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [3:0]  NUM_SEC_W = 4'(NUM_SECTIONS);
  localparam logic [2:0]  LAST_SEC  = 3'(NUM_SECTIONS - 1);
  localparam logic [15:0] LAST_DW   = 16'(DWELL_FRAMES - 1);

  state_t      state, state_nx;
  logic        pending, pending_nx;
  logic [2:0]  target, target_nx;
  logic [2:0]  seccion_nx;
  logic [15:0] dwell_nx;
  logic        change_nx, ack_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    target_nx  = target;
    seccion_nx = seccion;
    dwell_nx   = dwell_cnt;
    change_nx  = 1'b0;
    ack_nx     = 1'b0;

    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     state_nx = pause ? HOLD : RUN;
        HOLD:    state_nx = pause ? HOLD : RUN;
        default: state_nx = IDLE;
      endcase
    end

    if (!enable && state != IDLE) begin
      // Leaving an active state discards any pending jump unacknowledged.
      seccion_nx = 3'd0;
      dwell_nx   = 16'd0;
      pending_nx = 1'b0;
      change_nx  = (seccion != 3'd0);
    end else begin
      if (state == IDLE) begin
        if (pending) begin
          seccion_nx = target;
          dwell_nx   = 16'd0;
          ack_nx     = 1'b1;
          change_nx  = (target != seccion);
          pending_nx = 1'b0;
        end
      end else if (frame_start) begin
        if (pending) begin
          seccion_nx = target;
          dwell_nx   = 16'd0;
          ack_nx     = 1'b1;
          change_nx  = (target != seccion);
          pending_nx = 1'b0;
        end else if (state == RUN) begin
          if (dwell_cnt == LAST_DW) begin
            seccion_nx = (seccion == LAST_SEC) ? 3'd0 : seccion + 3'd1;
            dwell_nx   = 16'd0;
            change_nx  = 1'b1;
          end else begin
            dwell_nx = dwell_cnt + 16'd1;
          end
        end
      end

      // Capture only from the pre-edge pending, so it never applies in its own cycle.
      if (jump_req && !pending && !jump_ack) begin
        pending_nx = 1'b1;
        target_nx  = ({1'b0, jump_sel} >= NUM_SEC_W) ? 3'd0 : jump_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending        <= 1'b0;
      target         <= 3'd0;
      seccion        <= 3'd0;
      dwell_cnt      <= 16'd0;
      seccion_change <= 1'b0;
      jump_ack       <= 1'b0;
    end else begin
      pending        <= pending_nx;
      target         <= target_nx;
      seccion        <= seccion_nx;
      dwell_cnt      <= dwell_nx;
      seccion_change <= change_nx;
      jump_ack       <= ack_nx;
    end
  end

endmodule
